// File: rtl/aes128_key_expansion.sv
// Iterative AES-128 key schedule: emits round keys 0..NR, one per rk handshake.
// A single subWord (four S-box lookups) is shared across all rounds, and rcon is
// advanced by xtime in its own register rather than derived from the round index.
module aes128_key_expansion #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_index,
    output logic [127:0] rk,
    output logic         busy
);

    localparam int unsigned KEY_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 4;

    // FIPS-197 S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    function automatic logic [BYTE_W-1:0] sbox(input logic [BYTE_W-1:0] x);
        return SBOX[{~x, 3'b000} +: BYTE_W];
    endfunction

    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    endfunction

    state_t state_q, state_d;

    logic [BYTE_W-1:0] rcon_q, rcon_d;
    logic [KEY_W-1:0]  rk_d;
    logic [IDX_W-1:0]  idx_d;

    logic [WORD_W-1:0] w0_c, w1_c, w2_c, w3_c;
    logic [WORD_W-1:0] rot_c, sub_c, t_c;
    logic [WORD_W-1:0] n0_c, n1_c, n2_c, n3_c;
    logic [KEY_W-1:0]  next_rk_c;
    logic              hs_c;
    logic              last_c;

    // Next round key from the current one: words are XOR-chained after the g() step.
    assign w0_c  = rk[127:96];
    assign w1_c  = rk[95:64];
    assign w2_c  = rk[63:32];
    assign w3_c  = rk[31:0];
    assign rot_c = {w3_c[23:0], w3_c[31:24]};
    assign sub_c = {sbox(rot_c[31:24]), sbox(rot_c[23:16]),
                    sbox(rot_c[15:8]),  sbox(rot_c[7:0])};
    assign t_c   = sub_c ^ {rcon_q, 24'h000000};
    assign n0_c  = w0_c ^ t_c;
    assign n1_c  = w1_c ^ n0_c;
    assign n2_c  = w2_c ^ n1_c;
    assign n3_c  = w3_c ^ n2_c;
    assign next_rk_c = {n0_c, n1_c, n2_c, n3_c};

    assign hs_c   = rk_valid & rk_ready;
    assign last_c = (rk_index == IDX_W'(NR));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave IDLE on a key, return after the last round is taken.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (key_valid)      state_d = EMIT;
            EMIT: if (hs_c && last_c) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Datapath next values: load key, advance a round per handshake, hold otherwise.
    always_comb begin
        rk_d   = rk;
        idx_d  = rk_index;
        rcon_d = rcon_q;
        unique case (state_q)
            IDLE: begin
                if (key_valid) begin
                    rk_d   = key;
                    idx_d  = '0;
                    rcon_d = 8'h01;
                end
            end
            EMIT: begin
                if (hs_c) begin
                    if (last_c) begin
                        idx_d = '0;
                    end else begin
                        rk_d   = next_rk_c;
                        idx_d  = rk_index + IDX_W'(1);
                        rcon_d = xtime(rcon_q);
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_ready <= 1'b1;
            rk_valid  <= 1'b0;
            busy      <= 1'b0;
            rk_index  <= '0;
            rk        <= '0;
            rcon_q    <= 8'h01;
        end else begin
            key_ready <= (state_d == IDLE);
            rk_valid  <= (state_d == EMIT);
            busy      <= (state_d == EMIT);
            rk_index  <= idx_d;
            rk        <= rk_d;
            rcon_q    <= rcon_d;
        end
    end

    // A valid round key never carries an index past the last round.
    rk_index_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
        rk_valid |-> (rk_index <= IDX_W'(NR)));

endmodule

// File: tb/tb_aes128_key_expansion.sv
// Directed bench for the AES-128 key schedule using FIPS-197 reference keys.
module tb_aes128_key_expansion;

    logic         clk;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_index;
    logic [127:0] rk;
    logic         busy;

    int vectors;
    int miscompares;

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ZERO = 128'h0;
    localparam logic [127:0] KEY_ALT  = 128'h000102030405060708090a0b0c0d0e0f;

    logic [127:0] exp_a1 [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic [127:0] exp_zero [11] = '{
        128'h00000000000000000000000000000000,
        128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
        128'h90973450696ccffaf2f457330b0fac99,
        128'hee06da7b876a1581759e42b27e91ee2b,
        128'h7f2e2b88f8443e098dda7cbbf34b9290,
        128'hec614b851425758c99ff09376ab49ba7,
        128'h217517873550620bacaf6b3cc61bf09b,
        128'h0ef903333ba9613897060a04511dfa9f,
        128'hb1d4d8e28a7db9da1d7bb3de4c664941,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e
    };

    aes128_key_expansion #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key       (key),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_index  (rk_index),
        .rk        (rk),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load a key and drain all 11 round keys, checking values, stalls and the return to idle.
    task automatic stream_key(input logic [127:0] k, input bit use_zero,
                              input int unsigned ready_pct, input int inject_round,
                              input string tag);
        logic [127:0] exp_rk;
        logic [127:0] prev_rk;
        logic [3:0]   prev_idx;
        bit           stalled;
        bit           rdy;
        int           hs;
        vectors++;
        if (key_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s key_ready before load: got %b want 1", tag, key_ready);
        end
        key       = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        vectors++;
        if (rk_valid !== 1'b1 || busy !== 1'b1 || key_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s load latency: rk_valid=%b busy=%b key_ready=%b want 1 1 0",
                     tag, rk_valid, busy, key_ready);
        end
        hs      = 0;
        stalled = 1'b0;
        prev_rk  = '0;
        prev_idx = '0;
        for (int cyc = 0; cyc < 400 && hs < 11; cyc++) begin
            rdy      = ($urandom_range(99) < ready_pct);
            rk_ready = rdy;
            if (inject_round >= 0 && hs >= inject_round && hs < 10) begin
                key       = KEY_ALT;
                key_valid = 1'b1;
                vectors++;
                if (key_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s key_ready during emit: got %b want 0", tag, key_ready);
                end
            end else begin
                key_valid = 1'b0;
            end
            exp_rk = use_zero ? exp_zero[hs] : exp_a1[hs];
            vectors++;
            if (rk_valid !== 1'b1 || rk_index !== 4'(hs) || rk !== exp_rk) begin
                miscompares++;
                $display("FAIL %s round %0d: valid=%b idx=%0d rk=%h want valid=1 idx=%0d rk=%h",
                         tag, hs, rk_valid, rk_index, rk, hs, exp_rk);
            end
            if (stalled) begin
                vectors++;
                if (rk !== prev_rk || rk_index !== prev_idx) begin
                    miscompares++;
                    $display("FAIL %s stall hold: idx=%0d rk=%h want idx=%0d rk=%h",
                             tag, rk_index, rk, prev_idx, prev_rk);
                end
            end
            prev_rk  = rk;
            prev_idx = rk_index;
            stalled  = rk_valid && !rdy;
            step();
            if (rdy && rk_valid !== 1'bx) hs++;
        end
        rk_ready  = 1'b0;
        key_valid = 1'b0;
        vectors++;
        if (hs != 11) begin
            miscompares++;
            $display("FAIL %s handshake count: got %0d want 11", tag, hs);
        end
        exp_rk = use_zero ? exp_zero[10] : exp_a1[10];
        vectors++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0 ||
            rk_index !== 4'd0 || rk !== exp_rk) begin
            miscompares++;
            $display("FAIL %s after last: ready=%b valid=%b busy=%b idx=%0d rk=%h want 1 0 0 0 %h",
                     tag, key_ready, rk_valid, busy, rk_index, rk, exp_rk);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        key_valid = 1'b0;
        rk_ready  = 1'b0;
        key       = '0;
        repeat (2) step();
        vectors++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0 ||
            rk_index !== 4'd0 || rk !== 128'h0) begin
            miscompares++;
            $display("FAIL reset values: ready=%b valid=%b busy=%b idx=%0d rk=%h want 1 0 0 0 0",
                     key_ready, rk_valid, busy, rk_index, rk);
        end
        rst_n = 1'b1;
        step();
        rk_ready = 1'b1;
        step();
        vectors++;
        if (rk_valid !== 1'b0 || rk_index !== 4'd0 || key_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL idle rk_ready: valid=%b idx=%0d ready=%b want 0 0 1",
                     rk_valid, rk_index, key_ready);
        end
        rk_ready = 1'b0;
    endtask

    task automatic test_fips_a1();
        stream_key(KEY_A1, 1'b0, 100, -1, "a1_stream");
    endtask

    task automatic test_zero_key();
        stream_key(KEY_ZERO, 1'b1, 100, -1, "zero_stream");
    endtask

    task automatic test_backpressure();
        stream_key(KEY_A1, 1'b0, 40, -1, "a1_backpressure");
    endtask

    task automatic test_key_during_emit();
        stream_key(KEY_A1, 1'b0, 100, 4, "key_in_emit");
    endtask

    task automatic test_async_reset();
        int c;
        key       = KEY_A1;
        key_valid = 1'b1;
        rk_ready  = 1'b1;
        step();
        key_valid = 1'b0;
        for (c = 0; c < 20 && rk_index != 4'd6; c++) step();
        rk_ready = 1'b0;
        vectors++;
        if (rk_index !== 4'd6 || rk !== exp_a1[6]) begin
            miscompares++;
            $display("FAIL areset reach round 6: idx=%0d rk=%h want 6 %h", rk_index, rk, exp_a1[6]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0 ||
            rk_index !== 4'd0 || rk !== 128'h0) begin
            miscompares++;
            $display("FAIL areset immediate: valid=%b ready=%b busy=%b idx=%0d rk=%h want 0 1 0 0 0",
                     rk_valid, key_ready, busy, rk_index, rk);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        stream_key(KEY_ZERO, 1'b1, 100, -1, "areset_zero");
    endtask

    task automatic test_back_to_back();
        key       = KEY_A1;
        key_valid = 1'b1;
        rk_ready  = 1'b1;
        step();
        key = KEY_ZERO;
        for (int i = 0; i <= 10; i++) begin
            vectors++;
            if (rk_valid !== 1'b1 || rk_index !== 4'(i) || rk !== exp_a1[i] || key_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b first round %0d: valid=%b idx=%0d rk=%h ready=%b want 1 %0d %h 0",
                         i, rk_valid, rk_index, rk, key_ready, i, exp_a1[i]);
            end
            step();
        end
        vectors++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b gap cycle: ready=%b valid=%b want 1 0", key_ready, rk_valid);
        end
        step();
        key_valid = 1'b0;
        vectors++;
        if (rk_valid !== 1'b1 || rk_index !== 4'd0 || rk !== KEY_ZERO || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b second round 0: valid=%b idx=%0d rk=%h busy=%b want 1 0 %h 1",
                     rk_valid, rk_index, rk, busy, KEY_ZERO);
        end
        for (int i = 1; i <= 10; i++) begin
            step();
            vectors++;
            if (rk_valid !== 1'b1 || rk_index !== 4'(i) || rk !== exp_zero[i]) begin
                miscompares++;
                $display("FAIL b2b second round %0d: valid=%b idx=%0d rk=%h want 1 %0d %h",
                         i, rk_valid, rk_index, rk, i, exp_zero[i]);
            end
        end
        step();
        rk_ready = 1'b0;
        vectors++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b final idle: ready=%b valid=%b busy=%b want 1 0 0",
                     key_ready, rk_valid, busy);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_fips_a1();
        test_zero_key();
        test_backpressure();
        test_key_during_emit();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
